adc_fifo_packetizer: RTL and testbench

Read-side drain engine for the ADC sample FIFO (1024x16 synchronous FIFO, non-FWFT, registered output). It pulls fixed-length bursts of 16-bit samples out of the FIFO, absorbs the FIFO read latency in a small skid buffer, and emits framed packets (header, payload, checksum) on a valid/ready stream toward the host link. One instance sits between the ADC FIFO read port and the uplink serializer.

---
 rtl/adc_fifo_packetizer_if.sv | 20 ++
 rtl/adc_fifo_packetizer.sv | 92 +++++++++
 tb/tb_adc_fifo_packetizer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_fifo_packetizer_if.sv
// adc_fifo_packetizer_if: FIFO read port and framed output stream of the packetizer
interface adc_fifo_packetizer_if;
  logic        fifo_empty;
  logic        fifo_aempty;
  logic        fifo_re;
  logic [15:0] fifo_q;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  modport master (
    input  fifo_empty, fifo_aempty, fifo_q, out_ready,
    output fifo_re, out_data, out_valid, out_sop, out_eop
  );
  modport slave (
    output fifo_empty, fifo_aempty, fifo_q, out_ready,
    input  fifo_re, out_data, out_valid, out_sop, out_eop
  );
endinterface

// File: rtl/adc_fifo_packetizer.sv
// adc_fifo_packetizer: drains fixed bursts from the ADC FIFO into header/payload/checksum packets
module adc_fifo_packetizer #(
  parameter int         BURST_LEN  = 64,
  parameter int         RD_LATENCY = 2,
  parameter int         SKID_DEPTH = 4,
  parameter logic [3:0] HDR_TAG    = 4'hA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  adc_fifo_packetizer_if.master bus,
  output logic                  o_busy,
  output logic                  o_underrun
);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] W_BL   = BW'(BURST_LEN);
  localparam logic [BW-1:0] W_LAST = BW'(BURST_LEN - 1);
  localparam logic [PW+1:0] W_SD   = (PW+2)'(SKID_DEPTH);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;
  state_t                r_state, w_next;
  logic [11:0]           r_seq;
  logic [15:0]           r_sum;
  logic [BW-1:0]         r_req, r_cnt;
  logic [RD_LATENCY-1:0] r_flight;
  logic [15:0]           r_skid [SKID_DEPTH];
  logic [PW-1:0]         r_wp, r_rp;
  logic [PW:0]           r_occ;
  logic                  r_underrun;
  logic [PW+1:0]         w_credit;
  logic                  w_fetch, w_push, w_hs, w_pop, w_active;
  // credit counts buffered words plus reads whose data is still in the FIFO pipeline
  always_comb begin
    w_credit = (PW+2)'(r_occ);
    for (int i = 0; i < RD_LATENCY; i++) w_credit = w_credit + (PW+2)'(r_flight[i]);
  end
  assign w_active      = r_state == HEADER || r_state == PAYLOAD;
  assign w_fetch       = w_active && r_req < W_BL && w_credit < W_SD;
  assign bus.fifo_re   = w_fetch && !bus.fifo_empty;
  assign w_push        = r_flight[RD_LATENCY-1];
  assign bus.out_valid = r_state == HEADER || r_state == CHECKSUM || (r_state == PAYLOAD && r_occ != '0);
  assign bus.out_sop   = r_state == HEADER;
  assign bus.out_eop   = r_state == CHECKSUM;
  assign w_hs          = bus.out_valid && bus.out_ready;
  assign w_pop         = r_state == PAYLOAD && w_hs;
  assign o_busy        = r_state != IDLE;
  assign o_underrun    = r_underrun;
  always_comb begin
    bus.out_data = r_state == HEADER ? {HDR_TAG, r_seq} :
                   (r_state == PAYLOAD && r_occ != '0) ? r_skid[r_rp] :
                   r_state == CHECKSUM ? r_sum : 16'h0;
    w_next = (r_state == IDLE && i_enable && !bus.fifo_aempty) ? HEADER :
             (r_state == HEADER && w_hs) ? PAYLOAD :
             (w_pop && r_cnt == W_LAST) ? CHECKSUM :
             (r_state == CHECKSUM && w_hs) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_seq      <= '0;
      r_sum      <= '0;
      r_req      <= '0;
      r_cnt      <= '0;
      r_flight   <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_occ      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_flight <= RD_LATENCY'({r_flight, bus.fifo_re});
      r_occ    <= r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_push) begin
        r_skid[r_wp] <= bus.fifo_q;
        r_wp         <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp  <= r_rp + 1'b1;
        r_sum <= r_sum + bus.out_data;
        r_cnt <= r_cnt + 1'b1;
      end
      if (bus.fifo_re) r_req <= r_req + 1'b1;
      if (w_fetch && bus.fifo_empty) r_underrun <= 1'b1;
      if (r_state == CHECKSUM && w_hs) r_seq <= r_seq + 1'b1;
      if (r_state == IDLE) begin
        r_sum <= '0;
        r_req <= '0;
        r_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_adc_fifo_packetizer.sv
// tb_adc_fifo_packetizer: directed checks of packet framing, stalls, underrun, reset and seq wrap
module tb_adc_fifo_packetizer;
  logic clk = 0, rst = 1, enable = 0, enable2 = 0, force_empty = 0, rnd_on = 0;
  logic busy, und, busy2, und2;
  always #5 clk = ~clk;
  adc_fifo_packetizer_if bus ();
  adc_fifo_packetizer_if bus2 ();
  adc_fifo_packetizer dut (.clk(clk), .rst(rst), .i_enable(enable), .bus(bus), .o_busy(busy), .o_underrun(und));
  adc_fifo_packetizer #(.BURST_LEN(2)) dut2 (.clk(clk), .rst(rst), .i_enable(enable2), .bus(bus2), .o_busy(busy2), .o_underrun(und2));
  // FIFO model with two-cycle read latency; reset discards unread contents
  logic [15:0] mem [256];
  int wp = 0, rp = 0;
  logic [15:0] pl;
  assign bus.fifo_empty = force_empty || (rp == wp);
  always @(posedge clk) begin
    if (rst) rp <= wp;
    else if (bus.fifo_re) begin
      pl <= mem[rp[7:0]];
      rp <= rp + 1;
    end
    bus.fifo_q <= pl;
  end
  assign bus2.fifo_empty  = 1'b0;
  assign bus2.fifo_aempty = 1'b0;
  assign bus2.fifo_q      = 16'hFFFF;
  assign bus2.out_ready   = 1'b1;
  int cyc = 0, re_cnt = 0, n_eop = 0, stall_bad = 0, occ_max = 0;
  logic [15:0] w_data [$];
  logic w_sop [$], w_eop [$];
  int w_cyc [$];
  logic p_stall = 0;
  logic [17:0] p_word = '0;
  always @(negedge clk) begin
    cyc++;
    if (bus.fifo_re) re_cnt++;
    if (p_stall && !(bus.out_valid && {bus.out_sop, bus.out_eop, bus.out_data} == p_word)) stall_bad++;
    p_stall = bus.out_valid && !bus.out_ready && !rst;
    p_word  = {bus.out_sop, bus.out_eop, bus.out_data};
    if (int'(dut.r_occ) > occ_max) occ_max = int'(dut.r_occ);
    if (bus.out_valid && bus.out_ready && !rst) begin
      w_data.push_back(bus.out_data);
      w_sop.push_back(bus.out_sop);
      w_eop.push_back(bus.out_eop);
      w_cyc.push_back(cyc);
      if (bus.out_eop) n_eop++;
    end
  end
  int n_hdr2 = 0, n_chk2 = 0, bad2 = 0;
  logic [15:0] hdr2_0 = '0, hdr2_4095 = '0, hdr2_4096 = '1;
  always @(negedge clk) begin
    if (bus2.out_valid && bus2.out_ready && !rst) begin
      if (bus2.out_sop) begin
        if (n_hdr2 == 0) hdr2_0 = bus2.out_data;
        if (n_hdr2 == 4095) hdr2_4095 = bus2.out_data;
        if (n_hdr2 == 4096) hdr2_4096 = bus2.out_data;
        n_hdr2++;
      end
      if (bus2.out_eop) begin
        n_chk2++;
        if (bus2.out_data !== 16'hFFFE) bad2++;
      end
    end
  end
  int n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_on) bus.out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic load(input logic [15:0] d0, input logic [15:0] inc, input int n);
    logic [15:0] d = d0;
    for (int i = 0; i < n; i++) begin
      mem[wp[7:0]] = d;
      wp++;
      d += inc;
    end
  endtask
  task automatic wait_eop(input string tag, input int k);
    int e0 = n_eop;
    for (int i = 0; i < 3000 && n_eop - e0 < k; i++) tick();
    check(tag, 32'(n_eop - e0), 32'(k));
  endtask
  task automatic check_pkt(input string tag, input int b, input logic [15:0] hdr, input logic [15:0] d0,
                           input logic [15:0] inc, input logic [15:0] sum);
    int bad = 0;
    logic [15:0] d = d0;
    if (w_data.size() < b + 66) begin
      check({tag, "_short"}, 32'(w_data.size() - b), 66);
      return;
    end
    check({tag, "_hdr"}, 32'({w_sop[b], w_eop[b], w_data[b]}), 32'({2'b10, hdr}));
    for (int i = 1; i <= 64; i++) begin
      if (w_sop[b+i] || w_eop[b+i] || w_data[b+i] !== d) bad++;
      d += inc;
    end
    check({tag, "_payload_bad"}, 32'(bad), 0);
    check({tag, "_chk"}, 32'({w_sop[b+65], w_eop[b+65], w_data[b+65]}), 32'({2'b01, sum}));
  endtask
  initial begin
    int b, r0, e0, v;
    bus.out_ready = 1;
    bus.fifo_aempty = 1;
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_re", 32'(bus.fifo_re), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_flags", 32'({bus.out_sop, bus.out_eop, busy, und}), 0);
    rst = 0;
    // basic packet with ready held high
    b = w_data.size(); r0 = re_cnt;
    load(16'h0001, 16'h0001, 64);
    bus.fifo_aempty = 0;
    enable = 1;
    tick();
    check("t1_hdr_flags", 32'({bus.out_valid, bus.out_sop, bus.fifo_re, busy}), 'hF);
    check("t1_hdr_data", 32'(bus.out_data), 'hA000);
    wait_eop("t1_eop", 1);
    enable = 0;
    check("t1_len", 32'(w_data.size() - b), 66);
    check_pkt("t1", b, 16'hA000, 16'h0001, 16'h0001, 16'h0820);
    check("t1_reads", 32'(re_cnt - r0), 64);
    check("t1_first_lat", 32'(w_cyc[b+1] - w_cyc[b] >= 3), 1);
    check("t1_rate", 32'(w_cyc[b+64] - w_cyc[b+1]), 63);
    // random back-pressure
    b = w_data.size(); r0 = re_cnt;
    load(16'h0001, 16'h0001, 64);
    enable = 1;
    rnd_on = 1;
    wait_eop("t2_eop", 1);
    enable = 0;
    rnd_on = 0;
    bus.out_ready = 1;
    check("t2_len", 32'(w_data.size() - b), 66);
    check_pkt("t2", b, 16'hA001, 16'h0001, 16'h0001, 16'h0820);
    check("t2_reads", 32'(re_cnt - r0), 64);
    check("t2_stable", 32'(stall_bad), 0);
    check("t2_occ_max", 32'(occ_max <= 4), 1);
    // back-to-back packets
    b = w_data.size();
    load(16'h0001, 16'h0001, 128);
    enable = 1;
    wait_eop("t3_eop", 2);
    enable = 0;
    check("t3_len", 32'(w_data.size() - b), 132);
    check_pkt("t3a", b, 16'hA002, 16'h0001, 16'h0001, 16'h0820);
    check_pkt("t3b", b + 66, 16'hA003, 16'h0041, 16'h0001, 16'h1820);
    check("t3_gap", 32'(w_cyc[b+66] - w_cyc[b+65]), 2);
    // underrun mid-payload
    b = w_data.size(); r0 = re_cnt;
    load(16'h0001, 16'h0001, 64);
    enable = 1;
    for (int i = 0; i < 200 && re_cnt - r0 < 10; i++) tick();
    force_empty = 1;
    check("t4_und_pre", 32'(und), 0);
    r0 = re_cnt;
    repeat (20) tick();
    check("t4_re_blocked", 32'(re_cnt - r0), 0);
    check("t4_und_set", 32'(und), 1);
    check("t4_busy_hold", 32'(busy), 1);
    force_empty = 0;
    wait_eop("t4_eop", 1);
    enable = 0;
    check("t4_len", 32'(w_data.size() - b), 66);
    check_pkt("t4", b, 16'hA004, 16'h0001, 16'h0001, 16'h0820);
    check("t4_und_sticky", 32'(und), 1);
    // enable dropped mid-payload
    b = w_data.size();
    load(16'h0001, 16'h0001, 64);
    enable = 1;
    for (int i = 0; i < 300 && w_data.size() - b < 21; i++) tick();
    enable = 0;
    wait_eop("t5_eop", 1);
    check("t5_len", 32'(w_data.size() - b), 66);
    check_pkt("t5", b, 16'hA005, 16'h0001, 16'h0001, 16'h0820);
    v = 0;
    repeat (10) begin
      tick();
      if (bus.out_valid || busy || bus.fifo_re) v++;
    end
    check("t5_stay_idle", 32'(v), 0);
    // reset during payload word 30
    b = w_data.size();
    load(16'h0001, 16'h0001, 64);
    enable = 1;
    for (int i = 0; i < 300 && w_data.size() - b < 31; i++) tick();
    e0 = n_eop;
    rst = 1;
    enable = 0;
    tick();
    check("t6_rst_out", 32'({bus.fifo_re, bus.out_valid, bus.out_sop, bus.out_eop, busy, und, bus.out_data}), 0);
    rst = 0;
    tick();
    check("t6_no_eop", 32'(n_eop - e0), 0);
    b = w_data.size();
    load(16'hFFFF, 16'h0000, 64);
    enable = 1;
    wait_eop("t6_eop", 1);
    enable = 0;
    check("t6_len", 32'(w_data.size() - b), 66);
    check_pkt("t6", b, 16'hA000, 16'hFFFF, 16'h0000, 16'hFFC0);
    // sequence wrap on a short-burst instance
    enable2 = 1;
    for (int i = 0; i < 40000 && n_hdr2 < 4097; i++) tick();
    enable2 = 0;
    repeat (12) tick();
    check("t7_hdr_count", 32'(n_hdr2), 4097);
    check("t7_chk_count", 32'(n_chk2), 4097);
    check("t7_hdr_first", 32'(hdr2_0), 'hA000);
    check("t7_hdr_4095", 32'(hdr2_4095), 'hAFFF);
    check("t7_hdr_wrap", 32'(hdr2_4096), 'hA000);
    check("t7_chk_bad", 32'(bad2), 0);
    check("t7_idle", 32'({busy2, und2}), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
